seg_display_scanner: RTL



---
 rtl/seg_display_scanner.sv | 75 +++++++
 1 files changed

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexed 7-segment scan controller with double-buffered value (optional LEADING_ZERO_BLANK_EN)
module seg_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  output logic [3:0]                    digit_bin,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          pending,
  output logic                          frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int VW = 4 * NUM_DIGITS;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] disp_q, disp_d, buf_q, buf_d;
  logic pend_q, pend_d, fdone_q, fdone_d, tick, wrap, blank;
  logic [3:0] bin_q, bin_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic [VW-1:0] upper;
`endif
  // next-state: prescaler, scan index, buffer commit at frame wrap, registered digit outputs
  always_comb begin
    tick    = en && cnt_q == CW'(REFRESH_DIV - 1);
    wrap    = tick && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d   = tick ? '0 : (en ? cnt_q + 1'b1 : cnt_q);
    idx_d   = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    disp_d  = (wrap && pend_q) ? buf_q : disp_q;
    buf_d   = load ? value : buf_q;
    pend_d  = load | (pend_q & ~wrap);
    fdone_d = wrap;
    bin_d   = disp_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    upper   = disp_d >> {idx_d, 2'b00};
    blank   = idx_d != '0 && upper == '0;
`else
    blank   = 1'b0;
`endif
    den_d   = (en && !blank) ? (NUM_DIGITS'(1) << idx_d) : '0;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      buf_q   <= '0;
      pend_q  <= 1'b0;
      fdone_q <= 1'b0;
      bin_q   <= '0;
      den_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      fdone_q <= fdone_d;
      bin_q   <= bin_d;
      den_q   <= den_d;
    end
  end
  assign digit_bin  = bin_q;
  assign digit_en   = den_q;
  assign digit_idx  = idx_q;
  assign pending    = pend_q;
  assign frame_done = fdone_q;
endmodule
